mult_sequencer: RTL and testbench

Multi-cycle signed multiplier controller. It accepts one WIDTH×WIDTH two's-complement operand pair through a valid/ready handshake and sequences a single shared shift-add accumulator over WIDTH cycles, one multiplier bit per cycle. It returns the 2·WIDTH-bit signed product through a second valid/ready handshake. It is the area-optimised alternative to the fully unrolled combinational multipliers, for paths that can tolerate WIDTH+2 cycles of latency.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_sequencer_if.sv | 31 +++
 rtl/mult_step.sv | 18 +
 rtl/mult_sequencer.sv | 116 +++++++++++
 tb/tb_mult_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential and combinational multipliers.
//   state_e       : sequencer FSM states
//   DEFAULT_WIDTH : default operand width
//   twos_neg()    : two's-complement negate of a value up to MAX_PW bits.
//                   Callers zero-extend into MAX_PW bits and truncate the result back.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MAX_PW        = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Low-order bits of the result are the correct negation at any narrower width.
  function automatic logic [MAX_PW-1:0] twos_neg(input logic [MAX_PW-1:0] x);
    return ~x + MAX_PW'(1);
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Operand/product handshake bundle for mult_sequencer.
//   in_valid/in_ready/a/b           : operand channel
//   out_valid/out_ready/product     : result channel
//   busy                            : block is not idle
// master = producer/consumer side, slave = multiplier side.
interface mult_sequencer_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mult_step.sv
// One shift-add step: acc_next = bit_in ? acc + (a_ext << sh) : acc, modulo 2^(2*WIDTH).
//   acc, a_ext : 2*WIDTH-bit accumulator and sign-extended multiplicand
//   sh         : shift amount (current multiplier bit index)
//   bit_in     : current multiplier magnitude bit
//   acc_next   : updated accumulator
module mult_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0]                        acc,
  input  logic [2*WIDTH-1:0]                        a_ext,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] sh,
  input  logic                                      bit_in,
  output logic [2*WIDTH-1:0]                        acc_next
);

  assign acc_next = bit_in ? (acc + (a_ext << sh)) : acc;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle signed multiplier: accepts a WIDTHxWIDTH operand pair, runs WIDTH
// shift-add steps on |b| through one shared mult_step, fixes the sign, then
// presents the 2*WIDTH-bit product until the consumer takes it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mult_sequencer_if.slave (operand and product handshakes, busy)
// WIDTH must be in 2..64 (twos_neg helper works on up to 128 bits).
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_sequencer_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   a_ext_q;
  logic [WIDTH-1:0] mag_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load;
  logic [PW-1:0]   step_acc;
  logic [WIDTH-1:0] b_mag;
  logic            in_ready_q, out_valid_q, busy_q;

  // |b| fits in WIDTH unsigned bits, including the most negative value.
  assign b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .a_ext    (a_ext_q),
    .sh       (cnt_q),
    .bit_in   (mag_q[cnt_q]),
    .acc_next (step_acc)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (neg_q) acc_d = PW'(twos_neg(MAX_PW'(acc_q)));
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands captured only on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_ext_q <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
    end else if (load) begin
      a_ext_q <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      mag_q   <= b_mag;
      neg_q   <= bus.b[WIDTH-1];
    end
  end

  // Handshake outputs registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = acc_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer (WIDTH=32): directed reset, latency,
// corner-operand and backpressure steps, then a randomized regression scored
// against a plain a*b reference with a FIFO of expected products.
module tb_mult_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned NRAND = 800;
  localparam int          LAT   = W + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mult_sequencer_if #(.WIDTH(W)) bif ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on the cycle after the accepting edge; counts cycles until out_valid.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (bif.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input string tag,
                         output logic [63:0] p);
    int n;
    int cyc;
    bif.a = x; bif.b = y; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    bif.in_valid = 1'b0;
    bif.a = $urandom;
    bif.b = $urandom;
    wait_valid(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(LAT));
    chk({tag, "_ref"}, bif.product, ref_mul(x, y));
    p = bif.product;
    tick();
    chk({tag, "_rdy_after"}, 64'(bif.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] p, held, exp_p;
    logic [63:0] exp_q[$];
    logic [31:0] pa, pb;
    int cyc, sent, recv, loops;
    logic saw;

    // Reset state
    rst_n = 1'b0;
    bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_product", bif.product, 64'd0);

    // Reset mid-RUN discards the operation
    bif.a = 32'd7; bif.b = 32'd9; bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("midrun_busy", 64'(bif.busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_in_ready", 64'(bif.in_ready), 64'd1);
    chk("midrun_out_valid", 64'(bif.out_valid), 64'd0);
    chk("midrun_product", bif.product, 64'd0);
    bif.out_ready = 1'b1;
    saw = 1'b0;
    repeat (50) begin
      tick();
      if (bif.out_valid === 1'b1) saw = 1'b1;
    end
    chk("midrun_no_output", 64'(saw), 64'd0);

    // Basic latency and corner operands
    run_one(32'd7, 32'hFFFF_FFFD, "basic", p);
    chk("basic_const", p, 64'hFFFF_FFFF_FFFF_FFEB);
    run_one(32'h8000_0000, 32'h8000_0000, "minmin", p);
    chk("minmin_const", p, 64'h4000_0000_0000_0000);
    run_one(32'h8000_0000, 32'h0000_0001, "minone", p);
    chk("minone_const", p, 64'hFFFF_FFFF_8000_0000);
    run_one(32'h0000_0000, 32'hFFFF_FFFF, "zeroneg", p);
    chk("zeroneg_const", p, 64'd0);
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxmax", p);
    chk("maxmax_const", p, 64'h3FFF_FFFF_0000_0001);

    // Output backpressure with a queued operand pair
    bif.out_ready = 1'b0;
    bif.a = 32'd12345; bif.b = 32'hFFFF_FD4A; bif.in_valid = 1'b1;
    tick();
    bif.a = $urandom; bif.b = $urandom;
    wait_valid(cyc);
    chk("bp_lat", 64'(cyc), 64'(LAT));
    chk("bp_prod1", bif.product, ref_mul(32'd12345, 32'hFFFF_FD4A));
    held = bif.product;
    repeat (10) begin
      bif.a = $urandom; bif.b = $urandom;
      tick();
      chk("bp_stable", bif.product, held);
      chk("bp_in_ready_low", 64'(bif.in_ready), 64'd0);
      chk("bp_valid_held", 64'(bif.out_valid), 64'd1);
    end
    bif.a = 32'hFFFF_FFF9; bif.b = 32'd1000;
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk("bp_idle_ready", 64'(bif.in_ready), 64'd1);
    chk("bp_idle_valid", 64'(bif.out_valid), 64'd0);
    tick();
    bif.in_valid = 1'b0;
    bif.a = $urandom; bif.b = $urandom;
    wait_valid(cyc);
    chk("bp_lat2", 64'(cyc), 64'(LAT));
    chk("bp_prod2", bif.product, 64'hFFFF_FFFF_FFFF_E4A8);
    bif.out_ready = 1'b1;
    tick();

    // Randomized regression with input/output stalls
    sent = 0; recv = 0; loops = 0;
    pa = rnd_op(); pb = rnd_op();
    while (recv < NRAND && loops < 80000) begin
      if (sent < NRAND && $urandom_range(0, 3) != 0) begin
        bif.in_valid = 1'b1; bif.a = pa; bif.b = pb;
      end else begin
        bif.in_valid = 1'b0; bif.a = $urandom; bif.b = $urandom;
      end
      bif.out_ready = ($urandom_range(0, 3) != 0);
      if (bif.in_valid && bif.in_ready === 1'b1) begin
        exp_q.push_back(ref_mul(pa, pb));
        sent++;
        pa = rnd_op(); pb = rnd_op();
      end
      if (bif.out_valid === 1'b1 && bif.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_p = exp_q.pop_front();
          chk("rand_prod", bif.product, exp_p);
        end
        recv++;
      end
      tick();
      loops++;
    end
    chk("rand_sent", 64'(sent), 64'(NRAND));
    chk("rand_recv", 64'(recv), 64'(NRAND));
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    saw = 1'b0;
    repeat (50) begin
      tick();
      if (bif.out_valid === 1'b1) saw = 1'b1;
    end
    chk("rand_no_extra", 64'(saw), 64'd0);
    chk("final_idle", 64'(bif.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
